light_phase_monitor: RTL and testbench
======================================

Name: light_phase_monitor

Overview:
- Downstream checker on the traffic light controller outputs (NS_red, NS_green, EW_red, EW_green).
- Each clock it samples the four lamp drives, tracks the current phase, and checks legality and dwell times.
- On a violation it latches a fault code and drives a fail-safe flashing-red request.
- Counts completed NS→EW→NS signal cycles for status/debug.

Parameters:
- MIN_GREEN, 4: minimum samples a green phase must last before leaving it.
- MAX_PHASE, 64: maximum samples any phase may last; must be < 2**DWELL_W.
- MIN_ALLRED, 1: minimum all-red samples between greens (used only with the optional feature).
- FLASH_DIV, 8: flash_red half-period in clock cycles.
- DWELL_W, 8: dwell counter width.
- CNT_W, 8: cycle_count width.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- NS_red  in  1  north-south red lamp drive.
- NS_green  in  1  north-south green lamp drive.
- EW_red  in  1  east-west red lamp drive.
- EW_green  in  1  east-west green lamp drive.
- clear_fault  in  1  one-cycle request to leave FAULT.
- fault  out  1  latched fault flag.
- fault_code  out  3  latched fault cause; 0 when no fault.
- flash_red  out  1  fail-safe flashing-red request.
- phase  out  2  current phase: 0 WAIT, 1 NS_GO, 2 EW_GO, 3 ALL_RED.
- cycle_count  out  CNT_W  completed signal cycles; wraps modulo 2**CNT_W.

Behaviour:
- Reset values (asynchronous): state=WAIT, fault=0, fault_code=0, flash_red=0, phase=0, cycle_count=0, dwell=0.
- All outputs are registered. A violation sampled at edge N is visible after edge N; latency is 1 cycle.
- Pattern decode per sample:
  - Direction legal iff exactly one of its red/green is 1.
  - NS_GO = NS green + EW red; EW_GO = EW green + NS red; ALL_RED = both red.
  - Both green -> CONFLICT (code 1).
  - Any illegal direction -> ILLEGAL (code 2).
- States: WAIT, NS_GO, EW_GO, ALL_RED, FAULT.
- WAIT: the first legal pattern enters the matching phase with dwell=1. CONFLICT or ILLEGAL goes to FAULT.
- Phase states:
  - Same pattern: dwell increments. If dwell is already MAX_PHASE, go to FAULT with STUCK (code 4).
  - Different legal pattern: dwell=1.
  - Leaving NS_GO or EW_GO with dwell < MIN_GREEN -> SHORT_GREEN (code 3).
  - Direct NS_GO<->EW_GO switches are legal unless the optional feature is compiled in.
- cycle_count increments on every entry to NS_GO whose previous green phase was EW_GO. Entry from WAIT does not count.
- Simultaneous violations take the lowest code: CONFLICT > ILLEGAL > SHORT_GREEN > STUCK > NO_ALLRED.
- FAULT:
  - fault=1; fault_code holds the first cause and is not overwritten.
  - flash_red goes to 1 on entry, then toggles every FLASH_DIV cycles.
  - clear_fault with a legal sampled pattern goes to WAIT: fault=0, code=0, flash_red=0, dwell=0. cycle_count is kept.
  - clear_fault with an illegal pattern is ignored.
  - clear_fault outside FAULT has no effect.
- Reset asserted mid-phase or mid-fault returns immediately to reset values.

Optional Feature:
- Macro: LIGHT_MON_ALLRED_CHECK_EN.
- Defined:
  - A green-to-green switch without an intervening ALL_RED is a NO_ALLRED fault (code 5).
  - An ALL_RED phase shorter than MIN_ALLRED before the next green is also a NO_ALLRED fault.
- Undefined: direct green-to-green switches are legal, code 5 is never produced, and MIN_ALLRED is unused.

Decomposition:
- Package light_mon_pkg holds:
  - state enum (WAIT, NS_GO, EW_GO, ALL_RED, FAULT);
  - phase encodings;
  - fault code constants FC_NONE=0, FC_CONFLICT=1, FC_ILLEGAL=2, FC_SHORT=3, FC_STUCK=4, FC_NOALLRED=5.
- One sub-module, light_flash_div: FLASH_DIV toggle generator, enabled only in FAULT and cleared on leaving it.

Test Plan:
- Reset pulse, then NS_GO for 10 cycles, EW_GO for 10, NS_GO -> phase 1,2,1; cycle_count=1; fault=0.
- NS_GO for 2 cycles then EW_GO (MIN_GREEN=4) -> fault=1, fault_code=3 one cycle after the switch edge; flash_red toggles every 8 cycles.
- Both greens=1 together with NS_red=1 (conflict and illegal at once) -> fault_code=1. Later patterns keep code 1. clear_fault while illegal is ignored; clear_fault after ALL_RED returns phase=0, fault=0.
- NS_GO held 65 samples (MAX_PHASE=64) -> fault_code=4 on the 65th sample edge.
- Reset asserted mid-EW_GO and mid-FAULT -> all outputs 0 immediately; after release, the next legal pattern resumes normal tracking.
- With LIGHT_MON_ALLRED_CHECK_EN, a direct NS_GO->EW_GO switch -> fault_code=5. Without the macro, the same stimulus gives no fault.

Source files
------------

// File: rtl/light_mon_pkg.sv
// light_mon_pkg
// Shared types and constants for the traffic light phase monitor.
//   state_t        : monitor FSM states (WAIT, NS_GO, EW_GO, ALL_RED, FAULT)
//   PH_*           : encodings driven on the 2-bit phase output
//   FC_*           : fault cause codes, lower value = higher priority
//   decode_pattern : maps the four lamp drives onto a phase state
//   is_green       : true for the two green phase states
package light_mon_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_NS_GO   = 3'd1,
        ST_EW_GO   = 3'd2,
        ST_ALL_RED = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [1:0] PH_WAIT    = 2'd0;
    localparam logic [1:0] PH_NS_GO   = 2'd1;
    localparam logic [1:0] PH_EW_GO   = 2'd2;
    localparam logic [1:0] PH_ALL_RED = 2'd3;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_ILLEGAL  = 3'd2;
    localparam logic [2:0] FC_SHORT    = 3'd3;
    localparam logic [2:0] FC_STUCK    = 3'd4;
    localparam logic [2:0] FC_NOALLRED = 3'd5;

    // Returns the phase a sampled lamp pattern represents, or ST_WAIT
    // when the pattern is not one of the three legal phases.
    function automatic state_t decode_pattern(input logic ns_red,
                                              input logic ns_green,
                                              input logic ew_red,
                                              input logic ew_green);
        state_t pat;
        pat = ST_WAIT;
        if (ns_green && !ns_red && ew_red && !ew_green)
            pat = ST_NS_GO;
        else if (ew_green && !ew_red && ns_red && !ns_green)
            pat = ST_EW_GO;
        else if (ns_red && !ns_green && ew_red && !ew_green)
            pat = ST_ALL_RED;
        return pat;
    endfunction

    function automatic logic is_green(input state_t s);
        return (s == ST_NS_GO) || (s == ST_EW_GO);
    endfunction

endpackage

// File: rtl/light_flash_div.sv
// light_flash_div
// Fail-safe flashing-red generator used while the monitor sits in FAULT.
//   clk       in  system clock
//   reset     in  asynchronous active-high reset
//   start     in  pulse on the edge that enters FAULT; forces flash_red high
//   hold      in  high while FAULT is kept; advances the divider
//   flash_red out toggles every FLASH_DIV cycles after start, 0 otherwise
module light_flash_div #(
    parameter int FLASH_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hold,
    output logic flash_red
);

    localparam int CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    logic [CW-1:0] div_cnt;

    // Entry loads a lit lamp and restarts the divider; any cycle that is
    // neither entry nor hold means FAULT was left, so everything clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            flash_red <= 1'b0;
        end else if (start) begin
            div_cnt   <= '0;
            flash_red <= 1'b1;
        end else if (hold) begin
            if (div_cnt == CW'(FLASH_DIV - 1)) begin
                div_cnt   <= '0;
                flash_red <= ~flash_red;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end else begin
            div_cnt   <= '0;
            flash_red <= 1'b0;
        end
    end

endmodule

// File: rtl/light_phase_monitor.sv
// light_phase_monitor
// Watches the traffic light controller lamp drives, tracks the active
// phase, checks legality and dwell times, latches the first fault cause
// and requests fail-safe flashing red until the fault is cleared.
//   clk          in  system clock
//   reset        in  asynchronous active-high reset
//   NS_red/NS_green/EW_red/EW_green  in  lamp drives sampled every clock
//   clear_fault  in  request to leave FAULT (honoured on a legal pattern)
//   fault        out latched fault flag
//   fault_code   out first fault cause (FC_*), 0 when healthy
//   flash_red    out flashing-red request
//   phase        out 0 WAIT, 1 NS_GO, 2 EW_GO, 3 ALL_RED
//   cycle_count  out completed NS->EW->NS cycles, wraps
// Build option: define LIGHT_MON_ALLRED_CHECK_EN to require an ALL_RED
// of at least MIN_ALLRED samples between any two green phases.
module light_phase_monitor
    import light_mon_pkg::*;
#(
    parameter int MIN_GREEN  = 4,
    parameter int MAX_PHASE  = 64,
    parameter int MIN_ALLRED = 1,
    parameter int FLASH_DIV  = 8,
    parameter int DWELL_W    = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NS_red,
    input  logic             NS_green,
    input  logic             EW_red,
    input  logic             EW_green,
    input  logic             clear_fault,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             flash_red,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] cycle_count
);

`ifdef LIGHT_MON_ALLRED_CHECK_EN
    localparam bit ALLRED_CHECK = 1'b1;
`else
    localparam bit ALLRED_CHECK = 1'b0;
`endif

    state_t             state, next_state;
    state_t             last_green, last_green_next;
    state_t             pat;
    logic [DWELL_W-1:0] dwell, dwell_next;
    logic [2:0]         viol;
    logic               conflict, illegal, count_inc;
    logic               fault_start, fault_hold;

    assign pat      = decode_pattern(NS_red, NS_green, EW_red, EW_green);
    assign conflict = NS_green & EW_green;
    assign illegal  = ~(NS_red ^ NS_green) | ~(EW_red ^ EW_green);

    assign fault_start = (state != ST_FAULT) && (next_state == ST_FAULT);
    assign fault_hold  = (state == ST_FAULT) && (next_state == ST_FAULT);

    // State register plus the registered side data: dwell, the last green
    // phase seen (ST_WAIT means none since WAIT), fault cause and cycle
    // counter. The cause is loaded only on entry so it is never overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_WAIT;
            last_green  <= ST_WAIT;
            dwell       <= '0;
            fault_code  <= FC_NONE;
            cycle_count <= '0;
        end else begin
            state      <= next_state;
            last_green <= last_green_next;
            dwell      <= dwell_next;
            if (fault_start)
                fault_code <= viol;
            else if (state == ST_FAULT && next_state != ST_FAULT)
                fault_code <= FC_NONE;
            if (count_inc)
                cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    // Next-state logic. Checks are written in priority order so the
    // lowest fault code wins when several violations coincide.
    always_comb begin
        next_state      = state;
        last_green_next = last_green;
        dwell_next      = dwell;
        viol            = FC_NONE;
        count_inc       = 1'b0;
        if (state == ST_FAULT) begin
            if (clear_fault && pat != ST_WAIT) begin
                next_state      = ST_WAIT;
                last_green_next = ST_WAIT;
                dwell_next      = '0;
            end
        end else begin
            if (conflict) begin
                viol = FC_CONFLICT;
            end else if (illegal) begin
                viol = FC_ILLEGAL;
            end else if (state == ST_WAIT) begin
                next_state = pat;
                dwell_next = DWELL_W'(1);
                if (is_green(pat))
                    last_green_next = pat;
            end else if (pat == state) begin
                if (dwell == DWELL_W'(MAX_PHASE))
                    viol = FC_STUCK;
                else
                    dwell_next = dwell + DWELL_W'(1);
            end else if (is_green(state) && dwell < DWELL_W'(MIN_GREEN)) begin
                viol = FC_SHORT;
            end else if (ALLRED_CHECK && is_green(pat) &&
                         (is_green(state) ||
                          (state == ST_ALL_RED && dwell < DWELL_W'(MIN_ALLRED)))) begin
                viol = FC_NOALLRED;
            end else begin
                next_state = pat;
                dwell_next = DWELL_W'(1);
                if (is_green(pat))
                    last_green_next = pat;
                if (pat == ST_NS_GO && last_green == ST_EW_GO)
                    count_inc = 1'b1;
            end
            if (viol != FC_NONE)
                next_state = ST_FAULT;
        end
    end

    // Output decode straight from the state register; FAULT reports phase 0.
    always_comb begin
        fault = 1'b0;
        phase = PH_WAIT;
        case (state)
            ST_NS_GO:   phase = PH_NS_GO;
            ST_EW_GO:   phase = PH_EW_GO;
            ST_ALL_RED: phase = PH_ALL_RED;
            ST_FAULT:   fault = 1'b1;
            default:    phase = PH_WAIT;
        endcase
    end

    light_flash_div #(
        .FLASH_DIV (FLASH_DIV)
    ) u_flash_div (
        .clk       (clk),
        .reset     (reset),
        .start     (fault_start),
        .hold      (fault_hold),
        .flash_red (flash_red)
    );

endmodule

// File: tb/tb_light_phase_monitor.sv
// tb_light_phase_monitor
// Directed-vector bench for light_phase_monitor with default parameters
// (MIN_GREEN=4, MAX_PHASE=64, FLASH_DIV=8). Expected values are worked out
// by hand from the lamp sequences applied in each test task.
// Honours LIGHT_MON_ALLRED_CHECK_EN for the green-to-green scenario.
module tb_light_phase_monitor;

    // Lamp patterns packed as {NS_red, NS_green, EW_red, EW_green}
    localparam logic [3:0] P_NS   = 4'b0110;
    localparam logic [3:0] P_EW   = 4'b1001;
    localparam logic [3:0] P_AR   = 4'b1010;
    localparam logic [3:0] P_CI   = 4'b1101;
    localparam logic [3:0] P_DARK = 4'b0000;

    logic       clk;
    logic       reset;
    logic       NS_red, NS_green, EW_red, EW_green;
    logic       clear_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_red;
    logic [1:0] phase;
    logic [7:0] cycle_count;

    int errors;
    int checks;

    light_phase_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .NS_red      (NS_red),
        .NS_green    (NS_green),
        .EW_red      (EW_red),
        .EW_green    (EW_green),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .flash_red   (flash_red),
        .phase       (phase),
        .cycle_count (cycle_count)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one lamp pattern for n sample edges, leaving the outputs
    // settled 1 ns after the last edge so they can be compared.
    task automatic applyStimulus(input logic [3:0] pat, input logic clr, input int n);
        for (int i = 0; i < n; i++) begin
            {NS_red, NS_green, EW_red, EW_green} = pat;
            clear_fault = clr;
            @(posedge clk);
            #1;
        end
        clear_fault = 1'b0;
    endtask

    // Short reset pulse between edges to return the monitor to WAIT.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Asynchronous reset must clear every output without a clock edge.
    task automatic test_reset();
        {NS_red, NS_green, EW_red, EW_green} = P_AR;
        clear_fault = 1'b0;
        reset = 1'b1;
        #3;
        checks++;
        if ({fault, fault_code, flash_red, phase, cycle_count} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h expected 0",
                     {fault, fault_code, flash_red, phase, cycle_count});
        end
        #10;
        reset = 1'b0;
    endtask

    // NS 10, EW 10, NS: phases 1,2,1 and one completed cycle; an idle
    // clear_fault does nothing and the count survives a fault/clear.
    task automatic test_normal_cycle();
        do_reset();
        applyStimulus(P_NS, 1'b0, 1);
        checks++;
        if (phase !== 2'd1) begin
            errors++;
            $display("[TB] FAIL normal_ns_entry: got %0d expected 1", phase);
        end
        applyStimulus(P_NS, 1'b0, 9);
        applyStimulus(P_NS, 1'b1, 1);
        checks++;
        if ({fault, phase} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL idle_clear: got fault=%0b phase=%0d expected 0/1", fault, phase);
        end
        applyStimulus(P_EW, 1'b0, 10);
        checks++;
        if ({phase, cycle_count} !== {2'd2, 8'd0}) begin
            errors++;
            $display("[TB] FAIL normal_ew: got phase=%0d count=%0d expected 2/0", phase, cycle_count);
        end
        applyStimulus(P_NS, 1'b0, 1);
        checks++;
        if ({fault, phase, cycle_count} !== {1'b0, 2'd1, 8'd1}) begin
            errors++;
            $display("[TB] FAIL normal_cycle_done: got fault=%0b phase=%0d count=%0d expected 0/1/1",
                     fault, phase, cycle_count);
        end
        applyStimulus(P_CI, 1'b0, 1);
        applyStimulus(P_AR, 1'b1, 1);
        checks++;
        if ({fault, cycle_count} !== {1'b0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL count_kept: got fault=%0b count=%0d expected 0/1", fault, cycle_count);
        end
    endtask

    // NS for 2 samples then EW: SHORT_GREEN one edge later, then the
    // flash request holds 8 cycles per level.
    task automatic test_short_green();
        do_reset();
        applyStimulus(P_NS, 1'b0, 2);
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_pre: got fault=%0b expected 0", fault);
        end
        applyStimulus(P_EW, 1'b0, 1);
        checks++;
        if ({fault, fault_code, flash_red} !== {1'b1, 3'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL short_code: got fault=%0b code=%0d flash=%0b expected 1/3/1",
                     fault, fault_code, flash_red);
        end
        applyStimulus(P_EW, 1'b0, 7);
        checks++;
        if (flash_red !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flash_hold_hi: got %0b expected 1", flash_red);
        end
        applyStimulus(P_EW, 1'b0, 1);
        checks++;
        if (flash_red !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flash_toggle_lo: got %0b expected 0", flash_red);
        end
        applyStimulus(P_EW, 1'b0, 7);
        checks++;
        if (flash_red !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flash_hold_lo: got %0b expected 0", flash_red);
        end
        applyStimulus(P_EW, 1'b0, 1);
        checks++;
        if ({flash_red, fault_code} !== {1'b1, 3'd3}) begin
            errors++;
            $display("[TB] FAIL flash_toggle_hi: got flash=%0b code=%0d expected 1/3", flash_red, fault_code);
        end
    endtask

    // Conflict plus illegal in one sample reports CONFLICT; later illegal
    // samples and an illegal clear leave it; a clear on ALL_RED recovers.
    task automatic test_conflict();
        do_reset();
        applyStimulus(P_NS, 1'b0, 5);
        applyStimulus(P_CI, 1'b0, 1);
        checks++;
        if ({fault, fault_code} !== {1'b1, 3'd1}) begin
            errors++;
            $display("[TB] FAIL conflict_code: got fault=%0b code=%0d expected 1/1", fault, fault_code);
        end
        applyStimulus(P_DARK, 1'b0, 2);
        applyStimulus(P_DARK, 1'b1, 1);
        checks++;
        if ({fault, fault_code} !== {1'b1, 3'd1}) begin
            errors++;
            $display("[TB] FAIL illegal_clear: got fault=%0b code=%0d expected 1/1", fault, fault_code);
        end
        applyStimulus(P_AR, 1'b1, 1);
        checks++;
        if ({fault, fault_code, flash_red, phase} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL legal_clear: got fault=%0b code=%0d flash=%0b phase=%0d expected 0/0/0/0",
                     fault, fault_code, flash_red, phase);
        end
        applyStimulus(P_AR, 1'b0, 1);
        checks++;
        if (phase !== 2'd3) begin
            errors++;
            $display("[TB] FAIL allred_after_clear: got %0d expected 3", phase);
        end
    endtask

    // NS held 64 samples is fine; the 65th trips STUCK.
    task automatic test_stuck();
        do_reset();
        applyStimulus(P_NS, 1'b0, 64);
        checks++;
        if ({fault, phase} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL stuck_edge64: got fault=%0b phase=%0d expected 0/1", fault, phase);
        end
        applyStimulus(P_NS, 1'b0, 1);
        checks++;
        if ({fault, fault_code} !== {1'b1, 3'd4}) begin
            errors++;
            $display("[TB] FAIL stuck_code: got fault=%0b code=%0d expected 1/4", fault, fault_code);
        end
    endtask

    // Reset asserted mid-EW_GO and mid-FAULT clears outputs at once;
    // tracking resumes from WAIT afterwards.
    task automatic test_reset_mid();
        do_reset();
        applyStimulus(P_NS, 1'b0, 5);
        applyStimulus(P_EW, 1'b0, 5);
        applyStimulus(P_NS, 1'b0, 5);
        applyStimulus(P_EW, 1'b0, 3);
        reset = 1'b1;
        #2;
        checks++;
        if ({fault, fault_code, flash_red, phase, cycle_count} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_ew: got %h expected 0",
                     {fault, fault_code, flash_red, phase, cycle_count});
        end
        reset = 1'b0;
        applyStimulus(P_EW, 1'b0, 1);
        checks++;
        if ({fault, phase} !== {1'b0, 2'd2}) begin
            errors++;
            $display("[TB] FAIL resume_ew: got fault=%0b phase=%0d expected 0/2", fault, phase);
        end
        applyStimulus(P_CI, 1'b0, 1);
        reset = 1'b1;
        #2;
        checks++;
        if ({fault, fault_code, flash_red, phase} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_fault: got fault=%0b code=%0d flash=%0b phase=%0d expected 0",
                     fault, fault_code, flash_red, phase);
        end
        reset = 1'b0;
        applyStimulus(P_NS, 1'b0, 1);
        checks++;
        if ({fault, phase} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL resume_ns: got fault=%0b phase=%0d expected 0/1", fault, phase);
        end
    endtask

    // Direct green-to-green switch faults only with the all-red check
    // built in; a switch through ALL_RED is legal either way.
    task automatic test_green_to_green();
        logic [3:0] exp_direct;
        do_reset();
        applyStimulus(P_NS, 1'b0, 5);
        applyStimulus(P_EW, 1'b0, 1);
`ifdef LIGHT_MON_ALLRED_CHECK_EN
        exp_direct = {1'b1, 3'd5};
`else
        exp_direct = {1'b0, 3'd0};
`endif
        checks++;
        if ({fault, fault_code} !== exp_direct) begin
            errors++;
            $display("[TB] FAIL direct_switch: got fault=%0b code=%0d expected %0b/%0d",
                     fault, fault_code, exp_direct[3], exp_direct[2:0]);
        end
        do_reset();
        applyStimulus(P_NS, 1'b0, 5);
        applyStimulus(P_AR, 1'b0, 2);
        applyStimulus(P_EW, 1'b0, 1);
        checks++;
        if ({fault, phase} !== {1'b0, 2'd2}) begin
            errors++;
            $display("[TB] FAIL switch_via_allred: got fault=%0b phase=%0d expected 0/2", fault, phase);
        end
    endtask

    // Runs every scenario in order and prints the summary line.
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_normal_cycle();
        test_short_green();
        test_conflict();
        test_stuck();
        test_reset_mid();
        test_green_to_green();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
